// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU.
// Holds the op encoding, FSM states and the multi-cycle op classifier.
package alu_pkg;

   // Encodings 14 and 15 are illegal; they execute as single-cycle ops with result 0.
   typedef enum logic [3:0] {
      ADD   = 4'd0,
      SUB   = 4'd1,
      AND   = 4'd2,
      OR    = 4'd3,
      XOR   = 4'd4,
      SLL   = 4'd5,
      SRL   = 4'd6,
      SRA   = 4'd7,
      SLT   = 4'd8,
      SLTU  = 4'd9,
      MUL   = 4'd10,
      MULHU = 4'd11,
      DIVU  = 4'd12,
      REMU  = 4'd13
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   function automatic logic is_multicycle(alu_op_t op);
      return op inside {MUL, MULHU, DIVU, REMU};
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// Ports: start/kill control, is_div/sel_hi select, op_a/op_b operands,
// done pulses on the last iteration with result valid in the same cycle.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            kill,
   input  logic            is_div,
   input  logic            sel_hi,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);

   // {hi_q, lo_q} is the product register for multiply and
   // {remainder, quotient} for divide; m_q is the fixed operand.
   logic [XLEN-1:0] hi_q, lo_q, m_q;
   logic [XLEN-1:0] hi_d, lo_d;
   logic [SHW-1:0]  cnt_q;
   logic            run_q, div_q, sel_q;

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] rem_df;
   logic            rem_ge;

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      rem_sh  = {hi_q, lo_q[XLEN-1]};
      rem_ge  = rem_sh >= {1'b0, m_q};
      // The true difference is below the divisor whenever rem_ge holds,
      // so XLEN bits are enough.
      rem_df  = rem_sh[XLEN-1:0] - m_q;
      if (div_q) begin
         hi_d = rem_ge ? rem_df : rem_sh[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], rem_ge};
      end else begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   assign done   = run_q && (cnt_q == '0);
   assign result = sel_q ? hi_d : lo_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
         div_q <= 1'b0;
         sel_q <= 1'b0;
      end else if (kill) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         hi_q  <= '0;
         lo_q  <= is_div ? op_a : op_b;
         m_q   <= is_div ? op_b : op_a;
         div_q <= is_div;
         sel_q <= sel_hi;
         cnt_q <= SHW'(XLEN - 1);
         run_q <= 1'b1;
      end else if (run_q) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (done) run_q <= 1'b0;
         else      cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides.
// Ports: clk/reset_n/flush, in_valid/in_ready + op/op1_data/op2_data/imm/use_imm,
// out_valid/out_ready + alu_out, busy while not idle.
module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  alu_op_t         op,
   input  logic [XLEN-1:0] op1_data,
   input  logic [XLEN-1:0] op2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_out,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   alu_state_t      state_q, state_d;
   logic [XLEN-1:0] opb, sc_res, md_res, out_q;
   logic            accept, mc, md_start, md_div, md_hi, md_done;

   assign opb = use_imm ? imm : op2_data;
   // reset_n gates in_ready so every output reads 0 while reset is held.
   assign in_ready = reset_n && !flush && (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign mc       = is_multicycle(op);
   assign md_start = accept && mc;
   assign md_div   = op inside {DIVU, REMU};
   assign md_hi    = op inside {MULHU, REMU};

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign alu_out   = out_q;

   always_comb begin
      sc_res = '0;
      case (op)
         ADD:     sc_res = op1_data + opb;
         SUB:     sc_res = op1_data - opb;
         AND:     sc_res = op1_data & opb;
         OR:      sc_res = op1_data | opb;
         XOR:     sc_res = op1_data ^ opb;
         SLL:     sc_res = op1_data << opb[SHW-1:0];
         SRL:     sc_res = op1_data >> opb[SHW-1:0];
         SRA:     sc_res = $signed(op1_data) >>> opb[SHW-1:0];
         SLT:     sc_res = {{(XLEN-1){1'b0}},
                            ($signed(op1_data) < $signed(opb))};
         SLTU:    sc_res = {{(XLEN-1){1'b0}}, (op1_data < opb)};
         default: sc_res = '0;
      endcase
   end

   alu_muldiv_iter #(
      .XLEN(XLEN)
   ) u_mdu (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (md_start),
      .kill   (flush),
      .is_div (md_div),
      .sel_hi (md_hi),
      .op_a   (op1_data),
      .op_b   (opb),
      .done   (md_done),
      .result (md_res)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = mc ? BUSY : DONE;
         BUSY:    if (md_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !mc)
            out_q <= sc_res;
         else if ((state_q == BUSY) && md_done && !flush)
            out_q <= md_res;
      end
   end

endmodule
